// File: rtl/accumulator_bank.sv
// Per-column signed accumulators with snapshot-and-drain into the output buffer.
// Mode 0 drains one reduced total, mode 1 drains one word per column.
module accumulator_bank #(
  parameter int unsigned ARR_SIZE    = 4,
  parameter int unsigned VERTICAL_BW = 32,
  parameter int unsigned ACC_W       = 40,
  parameter int unsigned OUT_W       = 32,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [ARR_SIZE*VERTICAL_BW-1:0] in_data,
  input  logic                            in_clear,
  input  logic                            acc_reset,
  input  logic                            store_req,
  input  logic [ADDR_W-1:0]               op_buffer_address,
  input  logic                            mode,
  input  logic                            sat_en,
  input  logic                            output_buffer_ready,
  output logic [OUT_W-1:0]                output_data,
  output logic [ADDR_W-1:0]               output_buffer_addr,
  output logic                            output_buffer_enable,
  output logic                            busy,
  output logic                            store_err,
  output logic                            overflow
);

  localparam int unsigned SUM_W = ACC_W + $clog2(ARR_SIZE);
  localparam int unsigned IDX_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_SIZE - 1);
  localparam logic signed [SUM_W-1:0] MAX_S = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_S = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, REDUCE = 2'd1, DRAIN = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q  [ARR_SIZE];
  logic signed [ACC_W-1:0]   acc_d  [ARR_SIZE];
  logic signed [ACC_W-1:0]   snap_q [ARR_SIZE];
  logic signed [ACC_W-1:0]   snap_d [ARR_SIZE];
  logic signed [ACC_W-1:0]   post_c [ARR_SIZE];
  logic signed [ACC_W-1:0]   sel_c;
  logic signed [SUM_W-1:0]   sum_c;
  logic [IDX_W-1:0]          idx_q, idx_d, nxt_idx_c;
  logic [ADDR_W-1:0]         base_q, base_d, addr_q, addr_d;
  logic [OUT_W-1:0]          data_q, data_d;
  logic                      mode_q, mode_d, sat_q, sat_d;
  logic                      en_q, en_d, busy_q, busy_d, err_q, err_d;
  logic                      ovf_q, ovf_d, pend_q, pend_d;
  logic                      store_ok_c;

  // Format a wide signed value to OUT_W; MSB of the result flags a value change.
  function automatic logic [OUT_W:0] fmt(input logic signed [SUM_W-1:0] x, input logic sat);
    logic [OUT_W-1:0]        lo;
    logic signed [SUM_W-1:0] ext;
    lo  = x[OUT_W-1:0];
    ext = SUM_W'($signed(lo));
    if (!sat)          fmt = {(ext != x), lo};
    else if (x > MAX_S) fmt = {1'b1, MAX_S[OUT_W-1:0]};
    else if (x < MIN_S) fmt = {1'b1, MIN_S[OUT_W-1:0]};
    else               fmt = {1'b0, lo};
  endfunction

  // Post-beat column values, reduced total and the next mode-1 drain word.
  always_comb begin
    sum_c     = '0;
    sel_c     = '0;
    nxt_idx_c = idx_q + IDX_W'(1);
    for (int unsigned k = 0; k < ARR_SIZE; k++) begin
      post_c[k] = (in_clear ? '0 : acc_q[k])
                + ACC_W'($signed(in_data[k*VERTICAL_BW +: VERTICAL_BW]));
      sum_c     = sum_c + SUM_W'(snap_q[k]);
      if (IDX_W'(k) == nxt_idx_c) sel_c = snap_q[k];
    end
    store_ok_c = store_req && (state_q == IDLE);
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    mode_d  = mode_q;
    sat_d   = sat_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = en_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    err_d   = store_req && (state_q != IDLE);
    for (int unsigned k = 0; k < ARR_SIZE; k++) begin
      snap_d[k] = snap_q[k];
      acc_d[k]  = acc_q[k];
      if (store_ok_c) snap_d[k] = acc_reset ? acc_q[k] : (in_valid ? post_c[k] : acc_q[k]);
      if (store_ok_c || acc_reset) acc_d[k] = '0;
      else if (in_valid)           acc_d[k] = post_c[k];
    end

    case (state_q)
      IDLE: begin
        if (store_ok_c) begin
          state_d = REDUCE;
          base_d  = op_buffer_address;
          mode_d  = mode;
          sat_d   = sat_en;
        end
      end
      REDUCE: begin
        state_d = DRAIN;
        en_d    = 1'b1;
        addr_d  = base_q;
        idx_d   = '0;
        {pend_d, data_d} = mode_q ? fmt(SUM_W'(snap_q[0]), sat_q) : fmt(sum_c, sat_q);
      end
      DRAIN: begin
        if (output_buffer_ready) begin
          ovf_d = ovf_q | pend_q;
          if (!mode_q || idx_q == LAST_IDX) begin
            state_d = IDLE;
            en_d    = 1'b0;
            addr_d  = '0;
            data_d  = '0;
            pend_d  = 1'b0;
          end else begin
            idx_d  = nxt_idx_c;
            addr_d = addr_q + ADDR_W'(1);
            {pend_d, data_d} = fmt(SUM_W'(sel_c), sat_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      mode_q  <= 1'b0;
      sat_q   <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      for (int unsigned k = 0; k < ARR_SIZE; k++) begin
        acc_q[k]  <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mode_q  <= mode_d;
      sat_q   <= sat_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      for (int unsigned k = 0; k < ARR_SIZE; k++) begin
        acc_q[k]  <= acc_d[k];
        snap_q[k] <= snap_d[k];
      end
    end
  end

  assign output_data          = data_q;
  assign output_buffer_addr   = addr_q;
  assign output_buffer_enable = en_q;
  assign busy                 = busy_q;
  assign store_err            = err_q;
  assign overflow             = ovf_q;

endmodule

// File: tb/tb_accumulator_bank.sv
// Bench for accumulator_bank: directed scenarios plus random traffic against a
// transaction-level model (expected drain beats are queued when a store is accepted).
module tb_accumulator_bank;

  localparam int ARR = 4;
  localparam int VB  = 32;
  localparam int ACCW = 40;
  localparam int OW  = 32;
  localparam int AW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_clear, acc_reset, store_req, mode, sat_en;
  logic [ARR*VB-1:0] in_data;
  logic [AW-1:0]     op_buffer_address;
  logic              output_buffer_ready;
  logic [OW-1:0]     output_data;
  logic [AW-1:0]     output_buffer_addr;
  logic              output_buffer_enable, busy, store_err, overflow;

  accumulator_bank #(.ARR_SIZE(ARR), .VERTICAL_BW(VB), .ACC_W(ACCW), .OUT_W(OW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_clear(in_clear),
    .acc_reset(acc_reset), .store_req(store_req), .op_buffer_address(op_buffer_address),
    .mode(mode), .sat_en(sat_en), .output_buffer_ready(output_buffer_ready),
    .output_data(output_data), .output_buffer_addr(output_buffer_addr),
    .output_buffer_enable(output_buffer_enable), .busy(busy), .store_err(store_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { longint data; int addr; bit ovf; } beat_t;
  typedef struct { longint data; int addr; } obs_t;

  beat_t  exp_q[$];
  obs_t   obs_q[$];
  longint m_acc [ARR];
  bit     m_busy, m_reduce, m_ovf, m_err;
  int     n_chk = 0;
  int     n_fail = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint wrap(input longint x, input int w);
    return (x <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic beat_t fmt(input longint x, input int addr, input bit sat);
    beat_t  b;
    longint hi, lo, r;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -(longint'(1) <<< (OW - 1));
    if (sat) r = (x > hi) ? hi : ((x < lo) ? lo : x);
    else     r = wrap(x, OW);
    b.ovf  = (r != x);
    b.data = r & ((longint'(1) <<< OW) - 1);
    b.addr = addr;
    return b;
  endfunction

  function automatic longint col(input int k);
    logic signed [VB-1:0] t;
    t = in_data[k*VB +: VB];
    return longint'(t);
  endfunction

  // Model: apply the spec's rules for one rising edge using the current inputs.
  task automatic model_edge();
    longint post [ARR];
    longint snap [ARR];
    longint s;
    bit     was_busy;
    beat_t  b;
    if (!rst) begin
      foreach (m_acc[k]) m_acc[k] = 0;
      exp_q.delete();
      m_busy = 0; m_reduce = 0; m_ovf = 0; m_err = 0;
      return;
    end
    was_busy = m_busy;
    if (m_busy && !m_reduce && output_buffer_ready && exp_q.size() > 0) begin
      b = exp_q.pop_front();
      m_ovf |= b.ovf;
      if (exp_q.size() == 0) m_busy = 0;
    end
    m_reduce = 0;
    m_err    = 0;
    for (int k = 0; k < ARR; k++)
      post[k] = in_valid ? wrap((in_clear ? 0 : m_acc[k]) + col(k), ACCW) : m_acc[k];
    if (store_req && !was_busy) begin
      for (int k = 0; k < ARR; k++) snap[k] = acc_reset ? m_acc[k] : post[k];
      if (!mode) begin
        s = 0;
        for (int k = 0; k < ARR; k++) s += snap[k];
        exp_q.push_back(fmt(s, int'(op_buffer_address), sat_en));
      end else begin
        for (int k = 0; k < ARR; k++)
          exp_q.push_back(fmt(snap[k], (int'(op_buffer_address) + k) % (1 << AW), sat_en));
      end
      m_busy = 1; m_reduce = 1;
      foreach (m_acc[k]) m_acc[k] = 0;
    end else begin
      m_err = store_req;
      for (int k = 0; k < ARR; k++) m_acc[k] = acc_reset ? 0 : post[k];
    end
  endtask

  task automatic compare();
    bit en;
    en = m_busy && !m_reduce;
    chk("busy", busy, m_busy);
    chk("enable", output_buffer_enable, en);
    chk("store_err", store_err, m_err);
    chk("overflow", overflow, m_ovf);
    if (en && exp_q.size() > 0) begin
      chk("data", output_data, exp_q[0].data);
      chk("addr", output_buffer_addr, exp_q[0].addr);
    end else begin
      chk("data_idle", output_data, 0);
      chk("addr_idle", output_buffer_addr, 0);
    end
  endtask

  task automatic step();
    obs_t o;
    if (rst && output_buffer_enable && output_buffer_ready) begin
      o.data = longint'(output_data);
      o.addr = int'(output_buffer_addr);
      obs_q.push_back(o);
    end
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    rst = 1; in_valid = 0; in_clear = 0; acc_reset = 0; store_req = 0;
    mode = 0; sat_en = 0; op_buffer_address = '0; output_buffer_ready = 1; in_data = '0;
  endtask

  task automatic set_cols(input int c0, input int c1, input int c2, input int c3);
    in_data = {VB'(c3), VB'(c2), VB'(c1), VB'(c0)};
  endtask

  task automatic do_beat(input int c0, input int c1, input int c2, input int c3);
    in_valid = 1; set_cols(c0, c1, c2, c3);
    step();
    in_valid = 0; in_data = '0;
  endtask

  task automatic do_store(input int base, input bit md, input bit sat);
    store_req = 1; op_buffer_address = AW'(base); mode = md; sat_en = sat;
    step();
    store_req = 0;
  endtask

  task automatic drain();
    output_buffer_ready = 1;
    for (int i = 0; i < 40 && m_busy; i++) step();
    chk("drain_done", busy, 0);
  endtask

  task automatic pulse_rst();
    rst = 0; step(); rst = 1; step();
  endtask

  initial begin
    idle_inputs();
    // Reset with every input active
    rst = 0; in_valid = 1; store_req = 1; in_clear = 1; acc_reset = 1; mode = 1; sat_en = 1;
    op_buffer_address = 4'hF; set_cols(-1, 7, 9, 11);
    step(); step();
    chk("rst_en", output_buffer_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    idle_inputs();
    obs_q.delete();
    do_store(3, 0, 1);
    drain();
    chk("zero_cnt", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("zero_data", obs_q[0].data, 0);

    // Mode 0 reduction
    obs_q.delete();
    repeat (3) do_beat(1, 2, 3, 4);
    do_store(5, 0, 1);
    chk("m0_lat_reduce", output_buffer_enable, 0);
    step();
    chk("m0_lat_drain", output_buffer_enable, 1);
    drain();
    chk("m0_cnt", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      chk("m0_data", obs_q[0].data, 30);
      chk("m0_addr", obs_q[0].addr, 5);
    end

    // Mode 1 with address wrap and a stall on the second beat
    obs_q.delete();
    do_beat(10, -20, 30, -40);
    do_store(14, 1, 1);
    step();
    step();
    output_buffer_ready = 0;
    repeat (3) step();
    drain();
    chk("m1_cnt", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("m1_a0", obs_q[0].addr, 14); chk("m1_d0", obs_q[0].data, 10);
      chk("m1_a1", obs_q[1].addr, 15); chk("m1_d1", obs_q[1].data, 64'hFFFF_FFEC);
      chk("m1_a2", obs_q[2].addr, 0);  chk("m1_d2", obs_q[2].data, 30);
      chk("m1_a3", obs_q[3].addr, 1);  chk("m1_d3", obs_q[3].data, 64'hFFFF_FFD8);
    end

    // Saturation and truncation
    for (int s = 1; s >= 0; s--) begin
      pulse_rst();
      obs_q.delete();
      repeat (2) do_beat(32'h7FFF_FFFF, 0, 0, 0);
      do_store(0, 1, s[0]);
      drain();
      chk("sat_cnt", obs_q.size(), 4);
      if (obs_q.size() > 0) chk("sat_d0", obs_q[0].data, s ? 64'h7FFF_FFFF : 64'hFFFF_FFFE);
      chk("sat_ovf", overflow, 1);
    end
    pulse_rst();
    do_beat(5, 5, 5, 5);
    do_store(2, 1, 1);
    drain();
    chk("nosat_ovf", overflow, 0);

    // Accumulation and a rejected store while draining
    obs_q.delete();
    do_beat(3, 4, 5, 6);
    do_store(0, 1, 0);
    do_beat(1, 1, 1, 1);
    do_beat(1, 1, 1, 1);
    store_req = 1; step(); store_req = 0;
    chk("ovl_err", store_err, 1);
    step();
    chk("ovl_err_clr", store_err, 0);
    drain();
    chk("ovl_cnt", obs_q.size(), 4);
    if (obs_q.size() == 4) chk("ovl_d3", obs_q[3].data, 6);
    obs_q.delete();
    do_store(0, 0, 0);
    drain();
    if (obs_q.size() > 0) chk("ovl_sum", obs_q[0].data, 8);
    obs_q.delete();
    in_valid = 1; acc_reset = 1; set_cols(9, 9, 9, 9); step();
    in_valid = 0; acc_reset = 0;
    do_store(1, 0, 0);
    drain();
    if (obs_q.size() > 0) chk("accrst_sum", obs_q[0].data, 0);

    // Reset in the middle of a mode-1 drain
    obs_q.delete();
    do_beat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    do_beat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    do_store(0, 1, 1);
    step(); step(); step();
    rst = 0; step(); rst = 1;
    chk("midrst_en", output_buffer_enable, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf", overflow, 0);
    repeat (6) step();
    chk("midrst_cnt", obs_q.size(), 2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(299) != 0);
      in_valid   = $urandom_range(1);
      in_clear   = ($urandom_range(7) == 0);
      acc_reset  = ($urandom_range(31) == 0);
      store_req  = ($urandom_range(5) == 0);
      mode       = $urandom_range(1);
      sat_en     = $urandom_range(1);
      op_buffer_address   = AW'($urandom);
      output_buffer_ready = ($urandom_range(3) != 0);
      for (int k = 0; k < ARR; k++)
        in_data[k*VB +: VB] = ($urandom_range(3) == 0) ? VB'($urandom)
                                                       : VB'(int'($urandom_range(200)) - 100);
      step();
    end
    idle_inputs();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_bank.md
Name: accumulator_bank

Overview:
- Parametrised successor to the single-word column accumulator; sits below the systolic array and feeds the output buffer.
- Keeps one signed running sum per array column, with widened internal precision.
- On a store request it snapshots and clears the column sums, so accumulation of the next tile continues while the snapshot drains.
- Drains either one reduced total (mode 0) or all column totals (mode 1), with output-buffer backpressure and optional saturation.

Parameters:
- ARR_SIZE, 4: number of array columns.
- VERTICAL_BW, 32: width of each column input word, signed.
- ACC_W, 40: width of each column accumulator; must be >= VERTICAL_BW.
- OUT_W, 32: output word width.
- ADDR_W, 4: output buffer address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  column beat present.
- in_data  in  ARR_SIZE*VERTICAL_BW  column k is at [k*VERTICAL_BW +: VERTICAL_BW], signed.
- in_clear  in  1  with in_valid: overwrite the accumulators with this beat instead of adding it.
- acc_reset  in  1  synchronous clear of the column accumulators.
- store_req  in  1  snapshot-and-drain request.
- op_buffer_address  in  ADDR_W  base address, sampled with store_req.
- mode  in  1  0 = reduce all columns to one word; 1 = one word per column. Sampled with store_req.
- sat_en  in  1  1 = saturate to signed OUT_W; 0 = truncate. Sampled with store_req.
- output_buffer_ready  in  1  output buffer accepts a beat.
- output_data  out  OUT_W  drained word.
- output_buffer_addr  out  ADDR_W  write address.
- output_buffer_enable  out  1  output beat valid.
- busy  out  1  high in REDUCE or DRAIN.
- store_err  out  1  one-cycle pulse when a store_req is rejected.
- overflow  out  1  sticky flag for a saturate or truncate event.

Behaviour:
- Reset (rst=0 at an edge):
  - acc[k], snapshots, state=IDLE and every output go to 0.
  - An in-progress drain is aborted with no further beats.
- Accumulation (independent of the FSM state):
  - When in_valid=1, acc[k] <= (in_clear ? 0 : acc[k]) + sign-extend(in_data column k).
  - Latency is 1 cycle. acc[k] wraps modulo 2^ACC_W; no flag is raised for that wrap.
- acc_reset:
  - Clears acc[k] to 0 and has priority over in_valid; a beat in the same cycle is dropped.
  - Does not affect the snapshot, a drain in progress, or overflow.
- store_req accepted only in IDLE:
  - snap[k] captures the post-beat value, i.e. it includes any in_valid beat in the same cycle.
  - acc[k] <= 0 in the same edge. If acc_reset is also asserted, the snapshot is still taken.
  - base address, mode and sat_en are latched.
  - The FSM moves to REDUCE.
- store_req while busy: ignored; store_err=1 for exactly that cycle. Accumulators are untouched.
- FSM states:
  - IDLE: waits for store_req.
  - REDUCE: one cycle. In mode 0, computes sum = sum of snap[k] at width ACC_W+clog2(ARR_SIZE), signed. In mode 1, sets index=0. Goes to DRAIN.
  - DRAIN: holds output_buffer_enable=1. A beat transfers at an edge where enable and output_buffer_ready are both 1.
    - Mode 0: one beat with addr=base and data=fmt(sum).
    - Mode 1: ARR_SIZE beats, k=0..ARR_SIZE-1, with addr=(base+k) mod 2^ADDR_W and data=fmt(snap[k]).
    - After the last transfer the FSM returns to IDLE, and enable is 0 in the next cycle.
- Backpressure: while ready=0, output_data, output_buffer_addr and enable are held stable.
- First beat latency: enable rises 2 cycles after the store_req edge (IDLE -> REDUCE -> DRAIN).
- fmt(x):
  - sat_en=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat_en=0: keep the low OUT_W bits.
  - If the result differs from x in value, overflow is set to 1 at the transfer edge.
  - overflow is cleared only by rst.
- Outside DRAIN: output_data=0, output_buffer_addr=0, output_buffer_enable=0.

Test Plan:
- Reset: drive rst=0 for 2 cycles with all inputs active -> all outputs 0, busy=0. After rst=1, a store_req with zero accumulators in mode 0 drains data=0.
- Mode 0: 3 beats with columns {1,2,3,4} each, then store_req with addr=5 and ready=1 -> exactly one beat, data=30, addr=5, enable high 2 cycles after the request; busy falls afterwards.
- Mode 1 with wrap and backpressure: one beat {10,-20,30,-40}, base=14, ready low for 3 cycles at the second beat -> beats (14,10), (15,-20), (0,30), (1,-40). Data and address stay stable during the stall; 4 transfers total.
- Saturation:
  - Column 0 receives 0x7FFFFFFF twice, mode 1. With sat_en=1 -> data 0x7FFFFFFF and overflow=1.
  - Repeat after rst with sat_en=0 -> data 0xFFFFFFFE and overflow=1.
  - With column sums of 5 -> overflow stays 0.
- Overlap:
  - During a drain, in_valid beats of {1,1,1,1} x2 -> no corruption of the drained words, and store_err pulses for a store_req issued while busy.
  - The next accepted store in mode 0 yields 8.
  - acc_reset together with in_valid drops that beat.
- Reset mid-drain: rst=0 after the 2nd of 4 mode-1 beats -> enable is 0 the next cycle, state IDLE, no remaining beats, overflow 0.
